// File: rtl/forwarding_unit.sv
// Operand-forwarding select and load-use stall unit for the 5-stage core.
// Tracks the EX and MEM destinations and registers the EX mux selects.
module forwarding_unit #(
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_we,
    input  logic                  id_is_load,
    input  logic                  flush,
    input  logic                  mem_stall,
    output logic [2:0]            fwd_a_sel,
    output logic [2:0]            fwd_b_sel,
    output logic                  stall
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic                  is_load;
    } ex_slot_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
    } mem_slot_t;

    localparam logic [2:0] SEL_RF  = 3'b000;
    localparam logic [2:0] SEL_EXM = 3'b001;
    localparam logic [2:0] SEL_MWB = 3'b010;

    ex_slot_t  ex_q, ex_d;
    mem_slot_t mem_q, mem_d;
    logic [2:0] sel_a_q, sel_a_d;
    logic [2:0] sel_b_q, sel_b_d;

    logic rs1_ex, rs2_ex, rs1_mem, rs2_mem;
    logic accept;

    // R0 is hardwired zero, so a source of 0 never matches any producer
    always_comb begin
        rs1_ex  = id_rs1_used && (id_rs1 != '0) && ex_q.valid
                  && ex_q.we && (ex_q.rd == id_rs1);
        rs2_ex  = id_rs2_used && (id_rs2 != '0) && ex_q.valid
                  && ex_q.we && (ex_q.rd == id_rs2);
        rs1_mem = id_rs1_used && (id_rs1 != '0) && mem_q.valid
                  && mem_q.we && (mem_q.rd == id_rs1);
        rs2_mem = id_rs2_used && (id_rs2 != '0) && mem_q.valid
                  && mem_q.we && (mem_q.rd == id_rs2);
    end

    assign stall = id_valid && !flush && ex_q.valid && ex_q.is_load
                   && (rs1_ex || rs2_ex);

    assign accept = id_valid && !stall && !flush;

    always_comb begin
        mem_d   = '{valid: ex_q.valid, rd: ex_q.rd, we: ex_q.we};
        ex_d    = '0;
        sel_a_d = SEL_RF;
        sel_b_d = SEL_RF;
        if (accept) begin
            ex_d = '{valid: 1'b1, rd: id_rd, we: id_we,
                     is_load: id_is_load};
            // youngest producer (EX) takes priority over MEM
            if (rs1_ex)       sel_a_d = SEL_EXM;
            else if (rs1_mem) sel_a_d = SEL_MWB;
            if (rs2_ex)       sel_b_d = SEL_EXM;
            else if (rs2_mem) sel_b_d = SEL_MWB;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            sel_a_q <= SEL_RF;
            sel_b_q <= SEL_RF;
        end else if (!mem_stall) begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
        end
    end

    assign fwd_a_sel = sel_a_q;
    assign fwd_b_sel = sel_b_q;

endmodule
